// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/stop sequencer for the KGPRISC core (launch reset, free-run/single-step, halt/budget/abort stop).
// Build macro KGPRISC_HALT_MASK_EN adds a halt_mask input that disables individual halt sources.
module cpu_run_ctrl #(
    parameter int NUM_HALT_SRC = 4,
    parameter int CNT_W        = 32
) (
    input  logic                    clkf,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    step_mode,
    input  logic                    step,
    input  logic [NUM_HALT_SRC-1:0] halt_req,
`ifdef KGPRISC_HALT_MASK_EN
    input  logic [NUM_HALT_SRC-1:0] halt_mask,
`endif
    input  logic [CNT_W-1:0]        max_cycles,
    output logic                    cpu_en,
    output logic                    cpu_rst,
    output logic                    running,
    output logic                    stop,
    output logic [1:0]              halt_cause,
    output logic [NUM_HALT_SRC-1:0] halt_src,
    output logic [CNT_W-1:0]        cycle_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_STOPPED   = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_HALT   = 2'd1;
    localparam logic [1:0] CAUSE_BUDGET = 2'd2;
    localparam logic [1:0] CAUSE_ABORT  = 2'd3;

    // CNT_W must be at least 2 for these constants to be well formed.
    localparam logic [CNT_W-1:0]        CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]        CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_HALT_SRC-1:0] SRC_ZERO = {NUM_HALT_SRC{1'b0}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic                    start_q_r;
    logic                    step_q_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_s;
    logic [1:0]              cause_r;
    logic [1:0]              cause_s;
    logic [NUM_HALT_SRC-1:0] src_r;
    logic [NUM_HALT_SRC-1:0] src_s;
    logic                    cpu_rst_r;
    logic                    running_r;
    logic                    stop_r;
    logic                    en_s;

    logic                    start_rise_s;
    logic                    start_fall_s;
    logic                    step_rise_s;
    logic [NUM_HALT_SRC-1:0] halt_eff_s;
    logic                    halt_any_s;
    logic                    budget_hit_s;

    // Edge detection on the start and step request levels.
    always_comb begin
        start_rise_s = start & ~start_q_r;
        start_fall_s = ~start & start_q_r;
        step_rise_s  = step & ~step_q_r;
    end

    // Qualify halt requests and compare the enabled-cycle count against the live budget.
    always_comb begin
`ifdef KGPRISC_HALT_MASK_EN
        halt_eff_s = halt_req & ~halt_mask;
`else
        halt_eff_s = halt_req;
`endif
        halt_any_s   = |halt_eff_s;
        budget_hit_s = (max_cycles != CNT_ZERO) && (cnt_r == (max_cycles - CNT_ONE));
    end

    // Next-state, enable and stop-bookkeeping logic.
    always_comb begin
        state_s = state_r;
        en_s    = 1'b0;
        cnt_s   = cnt_r;
        cause_s = cause_r;
        src_s   = src_r;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_s   = CNT_ZERO;
                cause_s = CAUSE_NONE;
                src_s   = SRC_ZERO;
                if (step_mode) begin
                    state_s = ST_STEP_WAIT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN, ST_STEP_WAIT: begin
                // Abort is honoured on any cycle; halt and budget only on enabled cycles.
                if (state_r == ST_RUN) begin
                    en_s = 1'b1;
                end else begin
                    en_s = step_rise_s;
                end
                if (en_s) begin
                    cnt_s = sat_inc(cnt_r);
                end else begin
                    cnt_s = cnt_r;
                end
                if (start_fall_s) begin
                    state_s = ST_STOPPED;
                    cause_s = CAUSE_ABORT;
                end else if (en_s && halt_any_s) begin
                    state_s = ST_STOPPED;
                    cause_s = CAUSE_HALT;
                    src_s   = halt_eff_s;
                end else if (en_s && budget_hit_s) begin
                    state_s = ST_STOPPED;
                    cause_s = CAUSE_BUDGET;
                end else if (step_mode) begin
                    state_s = ST_STEP_WAIT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_STOPPED: begin
                if (start_rise_s) begin
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_STOPPED;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, edge-history, bookkeeping and status output registers.
    always_ff @(posedge clkf) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            start_q_r <= 1'b0;
            step_q_r  <= 1'b0;
            cnt_r     <= CNT_ZERO;
            cause_r   <= CAUSE_NONE;
            src_r     <= SRC_ZERO;
            cpu_rst_r <= 1'b0;
            running_r <= 1'b0;
            stop_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            start_q_r <= start;
            step_q_r  <= step;
            cnt_r     <= cnt_s;
            cause_r   <= cause_s;
            src_r     <= src_s;
            cpu_rst_r <= (state_s == ST_LAUNCH);
            running_r <= (state_s == ST_RUN) || (state_s == ST_STEP_WAIT);
            stop_r    <= (state_s == ST_STOPPED);
        end
    end

    assign cpu_en     = en_s;
    assign cpu_rst    = cpu_rst_r;
    assign running    = running_r;
    assign stop       = stop_r;
    assign halt_cause = cause_r;
    assign halt_src   = src_r;
    assign cycle_cnt  = cnt_r;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Parametrised run/stop sequencer for the KGPRISC core, replacing the bare start/stop handshake with a controlled one.
- Detects a start edge, pulses a CPU-local reset, then gates execution via cpu_en.
- Supports free-run and single-step modes; stops on any of N halt sources, a programmable cycle budget, or start withdrawal.
- Reports stop, halt cause and an enabled-cycle count to the top level.

Parameters:
NUM_HALT_SRC, 4, number of independent halt request inputs (>=1)
CNT_W, 32, width of cycle counter and cycle budget

Ports:
clkf  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  run request level; rising edge launches, falling edge while running aborts
step_mode  input  1  1 = single-step, 0 = free-run
step  input  1  step request; each rising edge grants one enabled cycle in step mode
halt_req  input  NUM_HALT_SRC  per-source halt request, sampled during enabled cycles
max_cycles  input  CNT_W  cycle budget; 0 = unlimited
cpu_en  output  1  CPU clock-enable (combinational from state and step edge)
cpu_rst  output  1  one-cycle CPU reset pulse at launch
running  output  1  high in RUN or STEP_WAIT
stop  output  1  high in STOPPED; held until next launch
halt_cause  output  2  0 none, 1 halt_req, 2 budget reached, 3 abort
halt_src  output  NUM_HALT_SRC  snapshot of halt_req at stop
cycle_cnt  output  CNT_W  number of enabled cycles since launch

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; start_q, step_q, cycle_cnt, halt_cause and halt_src = 0; cpu_rst=0; stop=0; running=0; cpu_en=0. Reset overrides every state, including mid-run.
- Edge detection:
  - start_q and step_q are registered copies of start and step.
  - start_rise = start & ~start_q; start_fall = ~start & start_q; step_rise = step & ~step_q.
  - If start is held high through reset, the cycle after rst falls sees start_rise and launches.
- IDLE: outputs low. On start_rise, go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - cpu_rst=1, cpu_en=0.
  - Clears cycle_cnt, halt_cause and halt_src; stop goes low.
  - Next state: STEP_WAIT if step_mode=1, else RUN.
- RUN:
  - cpu_en=1 every cycle; cycle_cnt increments per enabled cycle and saturates at all-ones.
  - Evaluated each cycle, in priority order:
    1. start_fall -> STOPPED, cause 3.
    2. |halt_req -> STOPPED, cause 1, halt_src <= halt_req.
    3. max_cycles != 0 and cycle_cnt == max_cycles-1 -> STOPPED, cause 2.
    4. step_mode=1 -> STEP_WAIT.
  - The cycle on which a stop is decided is still enabled and counted.
  - For cause 2, cycle_cnt ends equal to max_cycles.
- STEP_WAIT:
  - cpu_en = step_rise.
  - Halt, budget and abort checks use the same priority as RUN. Halt and budget checks apply only on enabled cycles; abort applies on any cycle.
  - step_mode=0 (and no stop) -> RUN.
- STOPPED:
  - stop=1, cpu_en=0; cause, halt_src and cycle_cnt are frozen.
  - start_rise -> LAUNCH. With start held high, the core stays stopped; start must drop and rise again to relaunch.
- start_rise in RUN or STEP_WAIT is impossible without a prior fall, so it is ignored.
- max_cycles is sampled live; changing it mid-run takes effect on the next compare.
- If max_cycles=1, the stop occurs on the first enabled cycle.

Optional Feature:
- Macro: KGPRISC_HALT_MASK_EN.
- Defined:
  - Adds input halt_mask [NUM_HALT_SRC].
  - Effective request = halt_req & ~halt_mask; it drives both the stop decision and the halt_src snapshot.
  - Fully masked sources never stop the core.
- Undefined: no port; all sources are always active.

Test Plan:
1. Launch and halt: rst=1 for 2 cycles; start=1, step_mode=0, max_cycles=0; assert halt_req=4'b0100 on the 5th RUN cycle -> cpu_rst pulses for 1 cycle after rst falls; cpu_en high 5 cycles; stop=1; halt_cause=1; halt_src=4'b0100; cycle_cnt=5.
2. Budget: max_cycles=10, no halts -> exactly 10 cpu_en cycles; stop=1; halt_cause=2; cycle_cnt=10. Repeat with max_cycles=1 -> cycle_cnt=1.
3. Simultaneous events: halt_req=4'b0001 on the same cycle cycle_cnt==max_cycles-1 -> halt_cause=1. Same cycle also with start_fall -> halt_cause=3.
4. Single-step: step_mode=1, three step pulses separated by 4 idle cycles -> exactly 3 single-cycle cpu_en pulses; cycle_cnt=3. Then step_mode=0 -> continuous cpu_en resumes.
5. Restart and reset mid-run: after stop, toggle start 1->0->1 -> new LAUNCH; cycle_cnt=0; cause=0. Assert rst during RUN with start held high -> IDLE, all outputs 0; relaunch on the first cycle after rst falls.
6. With KGPRISC_HALT_MASK_EN: halt_mask=4'b0010, halt_req=4'b0010 -> no stop. Then halt_req=4'b0011 -> stop; halt_src=4'b0001.
